video_timing_pattern_gen: RTL and testbench
===========================================

// Module: video_timing_pattern_gen
// PURPOSE
//  Parametrised video timing and test-pattern source for the HDMI path.
//  Generates hsync, vsync and data-enable for any CEA/VESA-style mode set by parameters.
//  Produces per-pixel RGB from a selectable pattern: solid, colour bars, checkerboard or grid.
//  Sits in the pixel clock domain. Its outputs feed the three TMDS encoders.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch, in pixels
//  H_SYNC     96   hsync width, in pixels
//  H_BP       48   horizontal back porch, in pixels
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch, in lines
//  V_SYNC     2    vsync width, in lines
//  V_BP       33   vertical back porch, in lines
//  HS_POL     1    hsync active level (1 = active-high)
//  VS_POL     1    vsync active level (1 = active-high)
//  COL_W      8    bits per colour channel
//  CNT_W      12   counter/coordinate width; must satisfy 2^CNT_W > both H_TOTAL and V_TOTAL
//  CHK_LOG2   4    checkerboard square size = 2^CHK_LOG2 pixels
//  GRID_LOG2  6    grid pitch = 2^GRID_LOG2 pixels
// PORTS
//  clk          in   1        pixel clock
//  rst_n        in   1        synchronous reset, active-low
//  en           in   1        1 = advance timing; 0 = freeze counters and all outputs
//  mode         in   2        pattern: 0 solid, 1 colour bars, 2 checker, 3 grid
//  fg_rgb       in   3*COL_W  foreground colour {R,G,B}
//  hsync        out  1        horizontal sync, polarity HS_POL
//  vsync        out  1        vertical sync, polarity VS_POL
//  de           out  1        data enable; high only in the active area
//  x            out  CNT_W    h_cnt of the current output pixel
//  y            out  CNT_W    v_cnt of the current output pixel
//  rgb          out  3*COL_W  pixel {R,G,B}
//  line_start   out  1        1-cycle pulse with pixel x==0
//  frame_start  out  1        1-cycle pulse with pixel (0,0)
// BEHAVIOUR
//  - Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
//  - Counters: h_cnt runs 0..H_TOTAL-1 and wraps to 0. At that wrap, v_cnt increments, wrapping at V_TOTAL-1 to 0.
//  - Output stage: every output is registered from the same (h_cnt,v_cnt). Latency is 1 cycle. All outputs stay mutually aligned.
//  - hsync is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
//  - vsync is active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines.
//  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). rgb = 0 whenever de = 0.
//  - Mode latching: mode is sampled only when decoding pixel (0,0), and that pixel already uses the new value. The latched mode_q then holds for the whole frame, so there is no mid-frame tearing.
//  - fg_rgb is sampled per pixel and is not latched.
//  - Mode 0 (solid): rgb = fg_rgb.
//  - Mode 1 (colour bars): BAR_W = H_ACTIVE/8, integer division.
//    - Bars in order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
//    - Leftover pixels at or beyond 8*BAR_W take black.
//    - Bar index comes from an incremental sub-counter, not a divider.
//  - Mode 2 (checker): rgb = (x[CHK_LOG2]^y[CHK_LOG2]) ? 0 : fg_rgb.
//  - Mode 3 (grid): rgb = fg_rgb when any of these hold, else 0:
//    - x[GRID_LOG2-1:0]==0
//    - y[GRID_LOG2-1:0]==0
//    - x==H_ACTIVE-1
//    - y==V_ACTIVE-1
//  - en=0: counters, bar sub-counter, mode_q and all outputs hold their values.
//  - Pulses while frozen: line_start and frame_start are held too, so a pulse held during freeze stays high.
//  - Resume: timing resumes on the next cycle with en=1, with no lost or duplicated pixel.
//  - Reset (rst_n=0 at a clock edge), taking priority over en:
//    - h_cnt, v_cnt, bar sub-counter and mode_q all go to 0.
//    - de=0, rgb=0, x=y=0, line_start=frame_start=0.
//    - hsync = ~HS_POL and vsync = ~VS_POL, i.e. inactive.
//  - Mid-frame reset restarts cleanly: the first edge with rst_n=1 and en=1 outputs pixel (0,0) with frame_start=1.
// TESTING
//  1. Defaults, en=1, 3 frames:
//     - frame_start period = 420000 cycles; 480 lines of 640 de cycles each.
//     - hsync high exactly for x 656..751.
//     - vsync high exactly for y 490..491, i.e. 1600 cycles.
//  2. Mode 1:
//     - pixels x=0..79 FFFFFF, x=80 FFFF00, x=160 00FFFF.
//     - x=560..639 000000; rgb=0 at x=640.
//  3. Mode 2, fg=FF00FF:
//     - (15,0) FF00FF, (16,0) 000000, (16,16) FF00FF.
//     - Mode 3, fg=00FF00: (64,5) 00FF00, (65,5) 0, (639,100) 00FF00.
//  4. Mode changes 0->2 at (300,200): the rest of that frame stays solid; checker starts at the next frame_start.
//  5. en=0 for 37 cycles at (100,10):
//     - all outputs frozen.
//     - after resume, the next pixel is (101,10) and the frame period grows by exactly 37.
//  6. rst_n=0 for 1 cycle at (300,200) -> reset values next cycle, then (0,0) with frame_start=1.
//     - Rerun 1 with H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, HS_POL=VS_POL=0: period = 14*7 = 98 cycles.

Source files
------------

// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen
//   Video timing and test-pattern source for the HDMI path. The pixel-clock domain
//   h/v counters drive registered hsync, vsync, data-enable, coordinates and a per-pixel
//   RGB value. The RGB value comes from a selectable pattern: solid, colour bars,
//   checkerboard or grid.
// Ports
//   i_clk          pixel clock
//   i_rst_n        synchronous reset, active-low (has priority over i_en)
//   i_en           1 = advance timing, 0 = freeze counters and all outputs
//   i_mode         pattern select: 0 solid, 1 colour bars, 2 checker, 3 grid
//   i_fg_rgb       foreground colour {R,G,B}, sampled every pixel
//   o_hsync        horizontal sync, active level HS_POL
//   o_vsync        vertical sync, active level VS_POL
//   o_de           data enable, high only inside the active area
//   o_x, o_y       coordinates of the pixel currently on the outputs
//   o_rgb          pixel colour {R,G,B}, zero outside the active area
//   o_line_start   high with every pixel at x==0
//   o_frame_start  high with pixel (0,0)
module video_timing_pattern_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b1,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned COL_W     = 8,
    parameter int unsigned CNT_W     = 12,
    parameter int unsigned CHK_LOG2  = 4,
    parameter int unsigned GRID_LOG2 = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [1:0]           i_mode,
    input  logic [3*COL_W-1:0]   i_fg_rgb,
    output logic                 o_hsync,
    output logic                 o_vsync,
    output logic                 o_de,
    output logic [CNT_W-1:0]     o_x,
    output logic [CNT_W-1:0]     o_y,
    output logic [3*COL_W-1:0]   o_rgb,
    output logic                 o_line_start,
    output logic                 o_frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // Guard against a zero bar width when H_ACTIVE < 8.
    localparam int unsigned BAR_W   = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
    localparam logic [3:0]       BAR_NONE = 4'd8;

    // Timing state: (r_h_cnt, r_v_cnt) is the pixel being decoded this cycle.
    logic [CNT_W-1:0]   r_h_cnt;
    logic [CNT_W-1:0]   r_v_cnt;
    logic [CNT_W-1:0]   r_bar_pix;   // position inside the current colour bar
    logic [3:0]         r_bar_idx;   // bar index 0..7, 8 = past the last full bar
    logic [1:0]         r_mode;

    logic               w_h_wrap;
    logic               w_v_wrap;
    logic               w_first;
    logic [1:0]         w_mode;
    logic               w_de;
    logic               w_hs_act;
    logic               w_vs_act;
    logic [2:0]         w_bar_bits;
    logic [3*COL_W-1:0] w_rgb;

    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_first  = (r_h_cnt == '0) && (r_v_cnt == '0);
    // The first pixel of a frame already uses the freshly sampled mode.
    assign w_mode   = w_first ? i_mode : r_mode;
    assign w_de     = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
    assign w_hs_act = (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
    assign w_vs_act = (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);

    // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        w_bar_bits = 3'b000;
        case (r_bar_idx)
            4'd0:    w_bar_bits = 3'b111;
            4'd1:    w_bar_bits = 3'b110;
            4'd2:    w_bar_bits = 3'b011;
            4'd3:    w_bar_bits = 3'b010;
            4'd4:    w_bar_bits = 3'b101;
            4'd5:    w_bar_bits = 3'b100;
            4'd6:    w_bar_bits = 3'b001;
            default: w_bar_bits = 3'b000;
        endcase
    end

    always_comb begin
        w_rgb = '0;
        if (w_de) begin
            unique case (w_mode)
                2'd0: w_rgb = i_fg_rgb;
                2'd1: w_rgb = {{COL_W{w_bar_bits[2]}}, {COL_W{w_bar_bits[1]}},
                               {COL_W{w_bar_bits[0]}}};
                2'd2: begin
                    if (!(r_h_cnt[CHK_LOG2] ^ r_v_cnt[CHK_LOG2])) begin
                        w_rgb = i_fg_rgb;
                    end
                end
                2'd3: begin
                    if ((r_h_cnt[GRID_LOG2-1:0] == '0) || (r_v_cnt[GRID_LOG2-1:0] == '0) ||
                        (r_h_cnt == H_ACT_C - 1'b1) || (r_v_cnt == V_ACT_C - 1'b1)) begin
                        w_rgb = i_fg_rgb;
                    end
                end
            endcase
        end
    end

    // Counters, bar sub-counter and mode latch.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_bar_pix <= '0;
            r_bar_idx <= '0;
            r_mode    <= '0;
        end else if (i_en) begin
            r_mode <= w_mode;
            if (w_h_wrap) begin
                r_h_cnt   <= '0;
                r_v_cnt   <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
                r_bar_pix <= '0;
                r_bar_idx <= '0;
            end else begin
                r_h_cnt <= r_h_cnt + 1'b1;
                if (r_bar_pix == BAR_LAST) begin
                    r_bar_pix <= '0;
                    if (r_bar_idx != BAR_NONE) begin
                        r_bar_idx <= r_bar_idx + 4'd1;
                    end
                end else begin
                    r_bar_pix <= r_bar_pix + 1'b1;
                end
            end
        end
    end

    // Output stage: everything registered from the same counter values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_rgb         <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            o_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
            o_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
            o_de          <= w_de;
            o_x           <= r_h_cnt;
            o_y           <= r_v_cnt;
            o_rgb         <= w_rgb;
            o_line_start  <= (r_h_cnt == '0);
            o_frame_start <= w_first;
        end
    end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
module tb_video_timing_pattern_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic [23:0] rgb;
        logic        ls;
        logic        fs;
    } out_t;

    typedef struct packed {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
        bit hpol, vpol;
        int chk, grid;
    } cfg_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] fg;

    logic a_hs, a_vs, a_de, a_ls, a_fs, b_hs, b_vs, b_de, b_ls, b_fs;
    logic [11:0] a_x, a_y, b_x, b_y;
    logic [23:0] a_rgb, b_rgb;
    out_t oa, ob;

    assign oa = {a_hs, a_vs, a_de, a_x, a_y, a_rgb, a_ls, a_fs};
    assign ob = {b_hs, b_vs, b_de, b_x, b_y, b_rgb, b_ls, b_fs};

    // Medium-sized mode: H_TOTAL=96, V_TOTAL=47, frame = 4512 cycles, BAR_W=10.
    video_timing_pattern_gen #(
        .H_ACTIVE(84), .H_FP(4), .H_SYNC(8), .H_BP(0),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .COL_W(8), .CNT_W(12),
        .CHK_LOG2(2), .GRID_LOG2(3)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_fg_rgb(fg),
        .o_hsync(a_hs), .o_vsync(a_vs), .o_de(a_de), .o_x(a_x), .o_y(a_y),
        .o_rgb(a_rgb), .o_line_start(a_ls), .o_frame_start(a_fs)
    );

    // Tiny mode with active-low syncs: 14 x 7 = 98 cycles per frame.
    video_timing_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .COL_W(8), .CNT_W(12),
        .CHK_LOG2(4), .GRID_LOG2(6)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_fg_rgb(fg),
        .o_hsync(b_hs), .o_vsync(b_vs), .o_de(b_de), .o_x(b_x), .o_y(b_y),
        .o_rgb(b_rgb), .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;

    cfg_t ca, cb;
    out_t qa[$], qb[$];
    int   ha = 0, va = 0, hb = 0, vb = 0;
    logic [1:0] mqa = '0, mqb = '0;
    out_t la = '0, lb = '0;

    // Frame statistics observed on DUT A (and period for DUT B).
    int   cyc = 0;
    int   fs_last_a = 0, per_a = 0, fs_last_b = 0, per_b = 0;
    int   acc_de = 0, acc_vs = 0, acc_hs = 0, fr_de = 0, fr_vs = 0, fr_hs = 0;
    logic fs_prev_a = 1'b0, fs_prev_b = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic out_t calc(input cfg_t c, input int h, input int v,
                                  input logic [1:0] m, input logic [23:0] f);
        out_t o;
        int   idx;
        logic [2:0] bits;
        o = '0;
        o.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
        o.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
        o.de = (h < c.ha) && (v < c.va);
        o.x  = h[11:0];
        o.y  = v[11:0];
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        if (o.de) begin
            case (m)
                2'd0: o.rgb = f;
                2'd1: begin
                    idx = h / (c.ha / 8);
                    case (idx)
                        0: bits = 3'b111;
                        1: bits = 3'b110;
                        2: bits = 3'b011;
                        3: bits = 3'b010;
                        4: bits = 3'b101;
                        5: bits = 3'b100;
                        6: bits = 3'b001;
                        default: bits = 3'b000;
                    endcase
                    o.rgb = {{8{bits[2]}}, {8{bits[1]}}, {8{bits[0]}}};
                end
                2'd2: if ((((h >> c.chk) ^ (v >> c.chk)) & 1) == 0) o.rgb = f;
                default: begin
                    if (h % (1 << c.grid) == 0 || v % (1 << c.grid) == 0 ||
                        h == c.ha - 1 || v == c.va - 1) o.rgb = f;
                end
            endcase
        end
        return o;
    endfunction

    // Predict what the next clock edge will put on the outputs.
    task automatic model_step(input cfg_t c, inout int h, inout int v,
                              inout logic [1:0] mq, inout out_t last);
        if (!rst_n) begin
            h = 0; v = 0; mq = '0;
            last = '0;
            last.hs = ~c.hpol;
            last.vs = ~c.vpol;
        end else if (en) begin
            if (h == 0 && v == 0) mq = mode;
            last = calc(c, h, v, mq, fg);
            h++;
            if (h == c.ha + c.hfp + c.hsw + c.hbp) begin
                h = 0;
                v++;
                if (v == c.va + c.vfp + c.vsw + c.vbp) v = 0;
            end
        end
    endtask

    task automatic tick();
        out_t ea, eb;
        model_step(ca, ha, va, mqa, la);
        qa.push_back(la);
        model_step(cb, hb, vb, mqb, lb);
        qb.push_back(lb);
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check("sb_a", 64'(oa), 64'(ea));
        check("sb_b", 64'(ob), 64'(eb));
        cyc++;
        if (oa.fs && !fs_prev_a) begin
            per_a = cyc - fs_last_a;
            fs_last_a = cyc;
            fr_de = acc_de; fr_vs = acc_vs; fr_hs = acc_hs;
            acc_de = 0; acc_vs = 0; acc_hs = 0;
        end
        fs_prev_a = oa.fs;
        acc_de += int'(oa.de);
        acc_vs += int'(oa.vs);
        acc_hs += int'(oa.hs);
        if (ob.fs && !fs_prev_b) begin
            per_b = cyc - fs_last_b;
            fs_last_b = cyc;
        end
        fs_prev_b = ob.fs;
    endtask

    // Advance at least one cycle, until DUT A shows pixel (x,y); bounded.
    task automatic run_to(input int x, input int y);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(oa.x == x[11:0] && oa.y == y[11:0]) && n < 10000);
        check("run_to_xy", {40'd0, oa.x, oa.y}, {40'd0, x[11:0], y[11:0]});
    endtask

    initial begin
        ca = '{ha: 84, hfp: 4, hsw: 8, hbp: 0, va: 40, vfp: 2, vsw: 2, vbp: 3,
               hpol: 1'b1, vpol: 1'b1, chk: 2, grid: 3};
        cb = '{ha: 8, hfp: 2, hsw: 2, hbp: 2, va: 4, vfp: 1, vsw: 1, vbp: 1,
               hpol: 1'b0, vpol: 1'b0, chk: 4, grid: 6};
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'd0;
        fg    = 24'h123456;

        // Reset state.
        tick();
        tick();
        check("rst_a_de", oa.de, 1'b0);
        check("rst_a_hs", oa.hs, 1'b0);
        check("rst_a_fs", oa.fs, 1'b0);
        check("rst_b_hs", ob.hs, 1'b1);
        check("rst_b_vs", ob.vs, 1'b1);

        // Three frames of free-running timing.
        rst_n = 1'b1;
        repeat (3 * 4512) tick();
        check("period_a", per_a, 4512);
        check("de_per_frame", fr_de, 84 * 40);
        check("vs_per_frame", fr_vs, 2 * 96);
        check("hs_per_frame", fr_hs, 8 * 47);
        check("period_b", per_b, 98);

        // Colour bars (BAR_W = 10, pixels 80..83 are leftover).
        mode = 2'd1;
        run_to(0, 0);
        check("bar_x0", oa.rgb, 24'hFFFFFF);
        run_to(9, 0);
        check("bar_x9", oa.rgb, 24'hFFFFFF);
        run_to(10, 0);
        check("bar_x10", oa.rgb, 24'hFFFF00);
        run_to(20, 0);
        check("bar_x20", oa.rgb, 24'h00FFFF);
        run_to(60, 0);
        check("bar_x60", oa.rgb, 24'h0000FF);
        run_to(81, 0);
        check("bar_leftover", oa.rgb, 24'h000000);
        run_to(84, 0);
        check("bar_blank_rgb", oa.rgb, 24'h000000);
        check("bar_blank_de", oa.de, 1'b0);

        // Checkerboard (4-pixel squares).
        mode = 2'd2;
        fg   = 24'hFF00FF;
        run_to(0, 0);
        run_to(3, 0);
        check("chk_3_0", oa.rgb, 24'hFF00FF);
        run_to(4, 0);
        check("chk_4_0", oa.rgb, 24'h000000);
        run_to(4, 4);
        check("chk_4_4", oa.rgb, 24'hFF00FF);

        // Grid (8-pixel pitch plus right/bottom edges).
        mode = 2'd3;
        fg   = 24'h00FF00;
        run_to(0, 0);
        run_to(8, 5);
        check("grid_8_5", oa.rgb, 24'h00FF00);
        run_to(9, 5);
        check("grid_9_5", oa.rgb, 24'h000000);
        run_to(83, 20);
        check("grid_83_20", oa.rgb, 24'h00FF00);
        run_to(9, 39);
        check("grid_9_39", oa.rgb, 24'h00FF00);

        // Mid-frame mode change only takes effect at the next frame.
        mode = 2'd0;
        fg   = 24'h123456;
        run_to(0, 0);
        run_to(30, 20);
        mode = 2'd2;
        run_to(5, 25);
        check("mode_hold_solid", oa.rgb, 24'h123456);
        run_to(0, 0);
        run_to(5, 25);
        check("mode_new_chk", oa.rgb, 24'h000000);

        // Freeze for 37 cycles at (10,3).
        run_to(0, 0);
        run_to(10, 3);
        en = 1'b0;
        repeat (37) tick();
        check("frz_x", oa.x, 12'd10);
        check("frz_y", oa.y, 12'd3);
        en = 1'b1;
        tick();
        check("resume_x", oa.x, 12'd11);
        check("resume_y", oa.y, 12'd3);
        run_to(0, 0);
        check("period_frz", per_a, 4512 + 37);

        // One-cycle reset mid-frame.
        run_to(30, 20);
        rst_n = 1'b0;
        tick();
        check("mrst_de", oa.de, 1'b0);
        check("mrst_x", oa.x, 12'd0);
        check("mrst_rgb", oa.rgb, 24'd0);
        check("mrst_fs", oa.fs, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_fs", oa.fs, 1'b1);
        check("post_rst_xy", {oa.x, oa.y}, 24'd0);
        check("post_rst_de", oa.de, 1'b1);
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
